// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done handshake, divide-by-zero flag.
// Define DIV_SIGNED_EN to add the sgn port and two's-complement operation (sign fix-up in the completion cycle).
module seq_divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic         sgn,
`endif
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

  state_t         state;
  logic [M-1:0]   prem;
  logic [N-1:0]   sreg;
  logic [M-1:0]   dvsr;
  logic [CW-1:0]  cnt;
  logic           neg_q;
  logic           neg_r;
  logic           s_mode;

`ifdef DIV_SIGNED_EN
  assign s_mode = sgn;
`else
  assign s_mode = 1'b0;
`endif

  function automatic logic [N-1:0] neg_n(input logic signed [N-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [M-1:0] neg_m(input logic signed [M-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // One restoring step: a failed trial keeps the shifted remainder, whose top bit is then known zero.
  logic [M:0]   shifted;
  logic         borrow;
  logic [M-1:0] prem_nxt;
  logic [N-1:0] sreg_nxt;

  always_comb begin
    shifted  = {prem, sreg[N-1]};
    borrow   = shifted < {1'b0, dvsr};
    prem_nxt = borrow ? shifted[M-1:0] : (shifted[M-1:0] - dvsr);
    sreg_nxt = {sreg[N-2:0], ~borrow};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      prem      <= '0;
      sreg      <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            prem  <= '0;
            cnt   <= CW'(N);
            neg_r <= s_mode & dividend[N-1];
            neg_q <= s_mode & (dividend[N-1] ^ divisor[M-1]);
            if (divisor == '0) begin
              // Raw dividend is kept so its low bits can be reported as the remainder.
              state <= ZERO;
              sreg  <= dividend;
              dvsr  <= '0;
            end else begin
              state <= RUN;
              sreg  <= neg_n(dividend, s_mode & dividend[N-1]);
              dvsr  <= neg_m(divisor, s_mode & divisor[M-1]);
            end
          end
        end
        RUN: begin
          prem <= prem_nxt;
          sreg <= sreg_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            dz        <= 1'b0;
            quotient  <= neg_n(sreg_nxt, neg_q);
            remainder <= neg_m(prem_nxt, neg_r);
          end
        end
        ZERO: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          dz        <= 1'b1;
          quotient  <= '1;
          remainder <= sreg[M-1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (N=8, M=4): handshake timing, zero divide, busy/reset behaviour,
// exhaustive unsigned sweep, and signed vectors when built with DIV_SIGNED_EN.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
`ifdef DIV_SIGNED_EN
  logic       sgn;
`endif
  logic       busy;
  logic       done;
  logic       dz;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(8), .M(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
`ifdef DIV_SIGNED_EN
    .sgn(sgn),
`endif
    .busy(busy),
    .done(done),
    .dz(dz),
    .quotient(quotient),
    .remainder(remainder)
  );

  initial forever #5 clk = ~clk;

  // Present operands with start for one edge; returns 1ns after the accept edge.
  task automatic accept(input logic [7:0] a, input logic [3:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycles from the accept edge until done is seen; -1 if it never arrives.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", dz); end
    checks++; if (quotient !== 8'h00 || remainder !== 4'h0) begin
      errors++; $display("FAIL reset_result: got q=%h r=%h expected q=00 r=0", quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    accept(8'd200, 4'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_done(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    checks++; if (quotient !== 8'd28 || remainder !== 4'd4 || dz !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_result: got q=%0d r=%0d dz=%b busy=%b expected q=28 r=4 dz=0 busy=0",
                         quotient, remainder, dz, busy);
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_back_to_back;
    int lat;
    accept(8'd255, 4'd15);
    wait_done(lat);
    checks++; if (lat !== 8 || quotient !== 8'd17 || remainder !== 4'd0) begin
      errors++; $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d expected lat=8 q=17 r=0", lat, quotient, remainder);
    end
    accept(8'd9, 4'd3);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    wait_done(lat);
    checks++; if (lat !== 8 || quotient !== 8'd3 || remainder !== 4'd0) begin
      errors++; $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d expected lat=8 q=3 r=0", lat, quotient, remainder);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    accept(8'h4D, 4'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dz_busy: got %b expected 1", busy); end
    wait_done(lat);
    checks++; if (lat !== 1 || quotient !== 8'hFF || remainder !== 4'hD || dz !== 1'b1) begin
      errors++; $display("FAIL dz_result: got lat=%0d q=%h r=%h dz=%b expected lat=1 q=ff r=d dz=1",
                         lat, quotient, remainder, dz);
    end
    accept(8'd10, 4'd3);
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_hold: got %b expected 1", dz); end
    wait_done(lat);
    checks++; if (lat !== 8 || quotient !== 8'd3 || remainder !== 4'd1 || dz !== 1'b0) begin
      errors++; $display("FAIL dz_clear: got lat=%0d q=%0d r=%0d dz=%b expected lat=8 q=3 r=1 dz=0",
                         lat, quotient, remainder, dz);
    end
  endtask

  task automatic test_busy_ignore;
    int pulses = 0;
    int first = -1;
    logic [7:0] q_seen = '0;
    logic [3:0] r_seen = '0;
    accept(8'd100, 4'd9);
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        dividend = 8'd50; divisor = 4'd5; start = 1'b1;
      end else begin
        start = 1'b0; dividend = 8'd77; divisor = 4'd2;
      end
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first < 0) begin first = c; q_seen = quotient; r_seen = remainder; end
      end
    end
    start = 1'b0;
    checks++; if (pulses !== 1 || first !== 8) begin
      errors++; $display("FAIL busy_ignore_pulses: got %0d pulses first at %0d expected 1 at 8", pulses, first);
    end
    checks++; if (q_seen !== 8'd11 || r_seen !== 4'd1) begin
      errors++; $display("FAIL busy_ignore_result: got q=%0d r=%0d expected q=11 r=1", q_seen, r_seen);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    accept(8'd100, 4'd9);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'h00 || remainder !== 4'h0 || dz !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h dz=%b expected all zero",
                         busy, done, quotient, remainder, dz);
    end
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    wait_done(lat);
    checks++; if (lat !== -1) begin errors++; $display("FAIL reset_mid_no_done: got done after %0d expected none", lat); end
    accept(8'd100, 4'd9);
    wait_done(lat);
    checks++; if (lat !== 8 || quotient !== 8'd11 || remainder !== 4'd1) begin
      errors++; $display("FAIL reset_mid_rerun: got lat=%0d q=%0d r=%0d expected lat=8 q=11 r=1", lat, quotient, remainder);
    end
  endtask

  task automatic test_exhaustive;
    int lat;
    int exp_lat;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ed;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 8'hFF; er = 4'(a % 16); ed = 1'b1; exp_lat = 1;
        end else begin
          eq = 8'(a / b); er = 4'(a % b); ed = 1'b0; exp_lat = 8;
        end
        accept(8'(a), 4'(b));
        wait_done(lat);
        checks++;
        if (lat !== exp_lat || quotient !== eq || remainder !== er || dz !== ed) begin
          errors++;
          $display("FAIL exhaustive %0d/%0d: got lat=%0d q=%0d r=%0d dz=%b expected lat=%0d q=%0d r=%0d dz=%b",
                   a, b, lat, quotient, remainder, dz, exp_lat, eq, er, ed);
        end
      end
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed;
    int lat;
    sgn = 1'b1;
    accept(8'h9C, 4'h7);
    wait_done(lat);
    checks++; if (lat !== 8 || quotient !== 8'hF2 || remainder !== 4'hE || dz !== 1'b0) begin
      errors++; $display("FAIL signed_neg_pos: got lat=%0d q=%h r=%h dz=%b expected lat=8 q=f2 r=e dz=0",
                         lat, quotient, remainder, dz);
    end
    accept(8'h80, 4'hF);
    wait_done(lat);
    checks++; if (lat !== 8 || quotient !== 8'h80 || remainder !== 4'h0 || dz !== 1'b0) begin
      errors++; $display("FAIL signed_overflow: got lat=%0d q=%h r=%h dz=%b expected lat=8 q=80 r=0 dz=0",
                         lat, quotient, remainder, dz);
    end
    accept(8'h64, 4'h9);
    wait_done(lat);
    checks++; if (lat !== 8 || quotient !== 8'hF2 || remainder !== 4'h2) begin
      errors++; $display("FAIL signed_pos_neg: got lat=%0d q=%h r=%h expected lat=8 q=f2 r=2", lat, quotient, remainder);
    end
    accept(8'h9C, 4'h0);
    wait_done(lat);
    checks++; if (lat !== 1 || quotient !== 8'hFF || remainder !== 4'hC || dz !== 1'b1) begin
      errors++; $display("FAIL signed_zero: got lat=%0d q=%h r=%h dz=%b expected lat=1 q=ff r=c dz=1",
                         lat, quotient, remainder, dz);
    end
    sgn = 1'b0;
    accept(8'h9C, 4'h7);
    wait_done(lat);
    checks++; if (quotient !== 8'd22 || remainder !== 4'd2) begin
      errors++; $display("FAIL signed_off: got q=%0d r=%0d expected q=22 r=2", quotient, remainder);
    end
  endtask
`endif

  initial begin
`ifdef DIV_SIGNED_EN
    sgn = 1'b0;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
